// File: rtl/bram_fifo_pkg.sv
// Shared widths and read-FSM encodings for the byte-in / word-out block-RAM FIFO controller.
package bram_fifo_pkg;
  localparam int BYTE_W       = 8;
  localparam int WORD_W       = 16;
  localparam int ADDR_A_W_DEF = 11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } rd_state_t;
endpackage

// File: rtl/bram_fifo_parity.sv
// Single-byte parity generator; PARITY_ODD selects odd (1) or even (0) parity.
module bram_fifo_parity
  import bram_fifo_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic [BYTE_W-1:0] i_data,
  output logic              o_par
);
  assign o_par = (^i_data) ^ PARITY_ODD;
endmodule

// File: rtl/bram_b2w_fifo_ctrl.sv
// Byte-in / word-out FIFO controller for a 9x2048 / 18x1024 mixed-width block RAM.
// Parity generate/check on the RAM parity bits is built only with BRAM_PARITY_CHECK_EN defined.
module bram_b2w_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int ADDR_A_W   = ADDR_A_W_DEF,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [BYTE_W-1:0]   S_DATA,
  input  logic                S_VALID,
  output logic                S_READY,
  output logic [WORD_W-1:0]   M_DATA,
  output logic                M_VALID,
  input  logic                M_READY,
  output logic [ADDR_A_W:0]   LEVEL,
  output logic [ADDR_A_W-1:0] RAM_ADDRA,
  output logic [BYTE_W-1:0]   RAM_DIA,
  output logic                RAM_DIPA,
  output logic                RAM_ENA,
  output logic                RAM_WEA,
  output logic                RAM_SSRA,
  output logic [ADDR_A_W-2:0] RAM_ADDRB,
  output logic                RAM_ENB,
  output logic                RAM_WEB,
  output logic                RAM_SSRB,
  input  logic [WORD_W-1:0]   RAM_DOB,
  input  logic [1:0]          RAM_DOPB,
  output logic                PAR_ERR
);
  localparam logic [ADDR_A_W:0] CAP = {1'b1, {ADDR_A_W{1'b0}}};

  logic [ADDR_A_W:0]   r_wptr;
  logic [ADDR_A_W-1:0] r_rptr;
  logic                r_run;
  logic [WORD_W-1:0]   r_mdata;
  rd_state_t           r_state;
  rd_state_t           w_state_nxt;
  logic [ADDR_A_W:0]   w_bytes;
  logic                w_accept;
  logic                w_pop;
  logic                w_enb;
  logic [ADDR_A_W-2:0] w_addrb;
  logic                w_word_avail;
  logic                w_two_words;

  // Occupancy includes the word sitting in M_DATA until it is popped.
  assign w_bytes      = r_wptr - {r_rptr, 1'b0};
  assign w_word_avail = (w_bytes >= (ADDR_A_W+1)'(2));
  assign w_two_words  = (w_bytes >= (ADDR_A_W+1)'(4));

  assign S_READY  = r_run && (w_bytes != CAP);
  assign w_accept = S_VALID && S_READY;
  assign LEVEL    = w_bytes;

  assign RAM_ENA   = w_accept;
  assign RAM_WEA   = w_accept;
  assign RAM_ADDRA = r_wptr[ADDR_A_W-1:0];
  assign RAM_DIA   = S_DATA;
  assign RAM_SSRA  = 1'b0;
  assign RAM_WEB   = 1'b0;
  assign RAM_SSRB  = 1'b0;
  assign RAM_ENB   = w_enb;
  assign RAM_ADDRB = w_addrb;
  assign M_DATA    = r_mdata;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_run  <= 1'b0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_accept) r_wptr <= r_wptr + (ADDR_A_W+1)'(1);
      if (w_pop)    r_rptr <= r_rptr + ADDR_A_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_word_avail) w_state_nxt = ST_FETCH;
      ST_FETCH: w_state_nxt = ST_VALID;
      ST_VALID: if (M_READY) w_state_nxt = w_two_words ? ST_FETCH : ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // A pop re-issues the read at the following word in the same cycle.
  always_comb begin
    M_VALID = (r_state == ST_VALID);
    w_pop   = (r_state == ST_VALID) && M_READY;
    w_enb   = ((r_state == ST_EMPTY) && w_word_avail) || (w_pop && w_two_words);
    w_addrb = w_pop ? (r_rptr[ADDR_A_W-2:0] + (ADDR_A_W-1)'(1)) : r_rptr[ADDR_A_W-2:0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                      r_mdata <= '0;
    else if (r_state == ST_FETCH) r_mdata <= RAM_DOB;
  end

`ifdef BRAM_PARITY_CHECK_EN
  logic w_par_a;
  logic w_par_lo;
  logic w_par_hi;
  logic r_par_err;

  bram_fifo_parity #(.PARITY_ODD(PARITY_ODD)) u_par_gen (.i_data(S_DATA),       .o_par(w_par_a));
  bram_fifo_parity #(.PARITY_ODD(PARITY_ODD)) u_par_lo  (.i_data(RAM_DOB[7:0]),  .o_par(w_par_lo));
  bram_fifo_parity #(.PARITY_ODD(PARITY_ODD)) u_par_hi  (.i_data(RAM_DOB[15:8]), .o_par(w_par_hi));

  // Registered so the pulse lines up with M_VALID rising.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_par_err <= 1'b0;
    else     r_par_err <= (r_state == ST_FETCH) &&
                          ((w_par_lo != RAM_DOPB[0]) || (w_par_hi != RAM_DOPB[1]));
  end

  assign RAM_DIPA = w_par_a;
  assign PAR_ERR  = r_par_err;
`else
  logic w_unused_par;
  assign w_unused_par = (^RAM_DOPB) ^ PARITY_ODD;
  assign RAM_DIPA     = 1'b0;
  assign PAR_ERR      = 1'b0;
`endif
endmodule

// File: tb/tb_bram_b2w_fifo_ctrl.sv
// Directed bench for bram_b2w_fifo_ctrl with a behavioural mixed-width RAM and a byte scoreboard.
module tb_bram_b2w_fifo_ctrl;
  localparam int AW = 11;

  logic          CLK;
  logic          RST;
  logic [7:0]    S_DATA;
  logic          S_VALID;
  logic          S_READY;
  logic [15:0]   M_DATA;
  logic          M_VALID;
  logic          M_READY;
  logic [AW:0]   LEVEL;
  logic [AW-1:0] RAM_ADDRA;
  logic [7:0]    RAM_DIA;
  logic          RAM_DIPA;
  logic          RAM_ENA;
  logic          RAM_WEA;
  logic          RAM_SSRA;
  logic [AW-2:0] RAM_ADDRB;
  logic          RAM_ENB;
  logic          RAM_WEB;
  logic          RAM_SSRB;
  logic [15:0]   RAM_DOB;
  logic [1:0]    RAM_DOPB;
  logic [1:0]    ram_dopb_q;
  logic          inj_err;
  logic          PAR_ERR;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb_q[$];

  bram_b2w_fifo_ctrl #(.ADDR_A_W(AW), .PARITY_ODD(1'b0)) dut (
    .CLK(CLK), .RST(RST),
    .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
    .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY),
    .LEVEL(LEVEL),
    .RAM_ADDRA(RAM_ADDRA), .RAM_DIA(RAM_DIA), .RAM_DIPA(RAM_DIPA),
    .RAM_ENA(RAM_ENA), .RAM_WEA(RAM_WEA), .RAM_SSRA(RAM_SSRA),
    .RAM_ADDRB(RAM_ADDRB), .RAM_ENB(RAM_ENB), .RAM_WEB(RAM_WEB), .RAM_SSRB(RAM_SSRB),
    .RAM_DOB(RAM_DOB), .RAM_DOPB(RAM_DOPB),
    .PAR_ERR(PAR_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural 9x2048 write / 18x1024 read RAM.
  logic [8:0] mem [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (RAM_ENA && RAM_WEA && !RAM_SSRA) mem[RAM_ADDRA] <= {RAM_DIPA, RAM_DIA};
    if (RAM_ENB && !RAM_WEB) begin
      RAM_DOB    <= {mem[{RAM_ADDRB, 1'b1}][7:0], mem[{RAM_ADDRB, 1'b0}][7:0]};
      ram_dopb_q <= {mem[{RAM_ADDRB, 1'b1}][8],   mem[{RAM_ADDRB, 1'b0}][8]};
    end
  end
  assign RAM_DOPB = ram_dopb_q ^ {inj_err, 1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every accepted byte is queued; every popped word must be the two oldest bytes.
  always @(negedge CLK) begin
    if (RST) sb_q.delete();
    else begin
      if (M_VALID && M_READY) begin
        if (sb_q.size() < 2) check("sb_underflow", sb_q.size(), 2);
        else begin
          check("sb_word", {16'h0, M_DATA}, {16'h0, sb_q[1], sb_q[0]});
          void'(sb_q.pop_front());
          void'(sb_q.pop_front());
        end
      end
      if (S_VALID && S_READY) sb_q.push_back(S_DATA);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    S_VALID = 1'b1;
    S_DATA  = b;
    tick();
    S_VALID = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic wait_mvalid(input string tag, input int budget);
    int c = 0;
    while (!M_VALID && c < budget) begin tick(); c++; end
    if (!M_VALID) check(tag, 0, 1);
  endtask

  task automatic wait_empty(input string tag, input int budget);
    int c = 0;
    while (LEVEL != 0 && c < budget) begin tick(); c++; end
    check(tag, LEVEL, 0);
  endtask

  initial begin
    logic prev;
    int   acc_cnt;
    bit   drv_done;

    RST = 1'b0; S_VALID = 1'b0; S_DATA = 8'h00; M_READY = 1'b1; inj_err = 1'b0;
    #2 RST = 1'b1;
    #20;
    check("rst_mvalid", M_VALID, 0);
    check("rst_mdata",  M_DATA,  0);
    check("rst_level",  LEVEL,   0);
    check("rst_sready", S_READY, 0);
    check("rst_parerr", PAR_ERR, 0);
    check("rst_enb",    RAM_ENB, 0);
    check("rst_ena",    RAM_ENA, 0);
    @(posedge CLK); #1 RST = 1'b0;
    check("sready_before_clk", S_READY, 0);
    tick();
    check("sready_after_clk", S_READY, 1);

    // 1: single word with zero-wait consumer
    S_VALID = 1'b1; S_DATA = 8'h11; #1;
    check("t1_ena",   RAM_ENA, 1);
    check("t1_addra", RAM_ADDRA, 0);
    check("t1_dia",   RAM_DIA, 8'h11);
`ifndef BRAM_PARITY_CHECK_EN
    S_DATA = 8'h07; #1;
    check("t1_dipa_off", RAM_DIPA, 0);
    S_DATA = 8'h11;
`endif
    tick();
    S_VALID = 1'b0;
    check("t1_enb_early", RAM_ENB, 0);
    push_byte(8'h22);
    check("t1_enb",   RAM_ENB, 1);
    check("t1_addrb", RAM_ADDRB, 0);
    check("t1_level2", LEVEL, 2);
    tick();
    check("t1_enb_pulse", RAM_ENB, 0);
    check("t1_fetch_mvalid", M_VALID, 0);
    tick();
    check("t1_mvalid", M_VALID, 1);
    check("t1_mdata",  M_DATA, 16'h2211);
    tick();
    check("t1_popped_mvalid", M_VALID, 0);
    check("t1_level0", LEVEL, 0);

    // 2: odd trailing byte is held back
    push_byte(8'hA1);
    push_byte(8'hB2);
    push_byte(8'hC3);
    wait_mvalid("t2_timeout", 10);
    check("t2_mdata", M_DATA, 16'hB2A1);
    tick();
    repeat (4) tick();
    check("t2_mvalid_idle", M_VALID, 0);
    check("t2_level1", LEVEL, 1);

    // 3: fill to capacity with the consumer stalled
    do_reset();
    M_READY = 1'b0;
    for (int i = 0; i < 2047; i++) push_byte(i[7:0]);
    check("t3_sready_2047", S_READY, 1);
    push_byte(8'hFF);
    check("t3_sready_full", S_READY, 0);
    check("t3_level_full",  LEVEL, 2048);
    check("t3_mvalid",      M_VALID, 1);
    check("t3_mdata",       M_DATA, 16'h0100);
    S_VALID = 1'b1; S_DATA = 8'h99; #1;
    check("t3_ena_blocked", RAM_ENA, 0);
    tick();
    S_VALID = 1'b0;
    check("t3_level_hold", LEVEL, 2048);
    M_READY = 1'b1;
    tick();
    check("t3_sready_after_pop", S_READY, 1);
    check("t3_level_after_pop",  LEVEL, 2046);
    check("t3_bubble", M_VALID, 0);
    prev = M_VALID;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t3_alternate", M_VALID, !prev);
      prev = M_VALID;
    end
    wait_empty("t3_drain", 3000);
    check("t3_sb_empty", sb_q.size(), 0);

    // 4: random gaps on both sides, wrapping the pointers twice
    acc_cnt  = 0;
    drv_done = 1'b0;
    fork
      begin
        for (int c = 0; c < 30000 && acc_cnt < 5000; c++) begin
          logic acc;
          S_VALID = ($urandom_range(0, 3) != 0);
          S_DATA  = 8'($urandom);
          acc = S_VALID && S_READY;
          tick();
          if (acc) acc_cnt++;
        end
        S_VALID  = 1'b0;
        drv_done = 1'b1;
      end
      begin
        for (int c = 0; c < 40000; c++) begin
          M_READY = $urandom_range(0, 1) == 1;
          tick();
          if (drv_done && LEVEL == 0) break;
        end
      end
    join
    check("t4_accepted", acc_cnt, 5000);
    check("t4_level", LEVEL, 0);
    check("t4_sb_empty", sb_q.size(), 0);
    M_READY = 1'b1;

    // 5: reset while a fetch is in flight
    do_reset();
    M_READY = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'h40 + i[7:0]);
    M_READY = 1'b1;
    tick();
    M_READY = 1'b0;
    check("t5_fetch_mvalid", M_VALID, 0);
    check("t5_fetch_level",  LEVEL, 6);
    RST = 1'b1; #1;
    check("t5_rst_mvalid", M_VALID, 0);
    check("t5_rst_level",  LEVEL, 0);
    check("t5_rst_sready", S_READY, 0);
    tick();
    RST = 1'b0;
    tick();
    M_READY = 1'b1;
    S_VALID = 1'b1; S_DATA = 8'h5A; #1;
    check("t5_addra0", RAM_ADDRA, 0);
    tick();
    S_VALID = 1'b0;
    push_byte(8'hA5);
    check("t5_enb",   RAM_ENB, 1);
    check("t5_addrb", RAM_ADDRB, 0);
    wait_mvalid("t5_timeout", 10);
    check("t5_mdata", M_DATA, 16'hA55A);
    tick();

`ifdef BRAM_PARITY_CHECK_EN
    // 6: corrupted high parity bit on one read
    do_reset();
    M_READY = 1'b0;
    push_byte(8'h3C);
    S_VALID = 1'b1; S_DATA = 8'h07; #1;
    check("t6_dipa", RAM_DIPA, 1);
    tick();
    S_VALID = 1'b0;
    tick();
    inj_err = 1'b1;
    check("t6_parerr_pre", PAR_ERR, 0);
    tick();
    inj_err = 1'b0;
    check("t6_parerr",  PAR_ERR, 1);
    check("t6_mvalid",  M_VALID, 1);
    check("t6_mdata",   M_DATA, 16'h073C);
    tick();
    check("t6_parerr_pulse", PAR_ERR, 0);
    M_READY = 1'b1;
    push_byte(8'h01);
    push_byte(8'h03);
    wait_mvalid("t6_timeout", 10);
    check("t6_clean_parerr", PAR_ERR, 0);
    tick();
`else
    check("nopar_parerr", PAR_ERR, 0);
    check("nopar_dipa",   RAM_DIPA, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
